// File: rtl/bnn_pkg.sv
// ============================================================================
// Module  : bnn_pkg
// Brief   : Shared types and helpers for the BNN stream loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } eval_state_t;

    // Width of a counter that must hold 0..n-1 (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/feat_shadow_buf.sv
// ============================================================================
// Module  : feat_shadow_buf
// Brief   : Assembles streamed feature beats into a shadow buffer with framing checks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module feat_shadow_buf
    import bnn_pkg::*;
#(
    parameter int FEAT_CNT  = 19,
    parameter int FEAT_BITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [FEAT_BITS-1:0]          in_data,
    input  logic                          in_last,
    output logic                          in_ready,
    input  logic                          clear,
    output logic [FEAT_CNT*FEAT_BITS-1:0] shadow,
    output logic                          shadow_full,
    output logic                          err_len
);

    localparam int               IDX_W    = cnt_width(FEAT_CNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEAT_CNT - 1);

    logic [IDX_W-1:0]     idx;
    logic [FEAT_BITS-1:0] mem [FEAT_CNT];
    logic                 accept;

    assign in_ready = !shadow_full;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx         <= '0;
            shadow_full <= 1'b0;
            err_len     <= 1'b0;
            for (int i = 0; i < FEAT_CNT; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem[idx] <= in_data;
                if (idx == LAST_IDX) begin
                    // A missing in_last is flagged but the sample is kept.
                    shadow_full <= 1'b1;
                    idx         <= '0;
                    if (!in_last) begin
                        err_len <= 1'b1;
                    end
                end else if (in_last) begin
                    idx     <= '0;
                    err_len <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (clear) begin
                shadow_full <= 1'b0;
            end
        end
    end

    generate
        for (genvar g = 0; g < FEAT_CNT; g++) begin : g_flat
            assign shadow[g*FEAT_BITS +: FEAT_BITS] = mem[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/bnn_stream_loader.sv
// ============================================================================
// Module  : bnn_stream_loader
// Brief   : Feature streaming front-end and prediction capture for the BNN classifier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_stream_loader
    import bnn_pkg::*;
#(
    parameter  int FEAT_CNT    = 19,
    parameter  int FEAT_BITS   = 4,
    parameter  int CLASS_CNT   = 3,
    parameter  int EVAL_CYCLES = 42,
    localparam int PRED_W      = $clog2(CLASS_CNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [FEAT_BITS-1:0]          in_data,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [FEAT_CNT*FEAT_BITS-1:0] features,
    output logic                          clf_rst,
    input  logic [PRED_W-1:0]             prediction,
    output logic [PRED_W-1:0]             pred_out,
    output logic                          pred_valid,
    input  logic                          pred_ready,
    output logic                          err_len
);

    localparam int               CNT_W    = cnt_width(EVAL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EVAL_CYCLES - 1);

    eval_state_t                   state;
    logic [CNT_W-1:0]              cnt;
    logic [FEAT_CNT*FEAT_BITS-1:0] shadow;
    logic                          shadow_full;
    logic                          xfer;

    // in_ready is low while shadow_full is set, so the copy never races a fill write.
    assign xfer = (state == ST_IDLE) && shadow_full;

    feat_shadow_buf #(
        .FEAT_CNT  (FEAT_CNT),
        .FEAT_BITS (FEAT_BITS)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .clear       (xfer),
        .shadow      (shadow),
        .shadow_full (shadow_full),
        .err_len     (err_len)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            features   <= '0;
            clf_rst    <= 1'b1;
            pred_out   <= '0;
            pred_valid <= 1'b0;
        end else begin
            clf_rst <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (shadow_full) begin
                        features <= shadow;
                        clf_rst  <= 1'b1;
                        cnt      <= CNT_LOAD;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt == '0) begin
                        pred_out   <= prediction;
                        pred_valid <= 1'b1;
                        state      <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (pred_valid && pred_ready) begin
                        pred_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bnn_stream_loader.sv
// Testbench for bnn_stream_loader: event-level reference model plus directed and random traffic.
`default_nettype none

module tb_bnn_stream_loader;

    localparam int FC = 19;
    localparam int FB = 4;
    localparam int CC = 3;
    localparam int EC = 42;
    localparam int PW = 2;
    localparam int FW = FC * FB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [FB-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [FW-1:0] features;
    logic          clf_rst;
    logic [PW-1:0] prediction = '0;
    logic [PW-1:0] pred_out;
    logic          pred_valid;
    logic          pred_ready = 1'b0;
    logic          err_len;

    logic          v1 = 1'b0;
    logic [FB-1:0] d1 = '0;
    logic          l1 = 1'b0;
    logic          r1;
    logic [FW-1:0] f1;
    logic          c1;
    logic [PW-1:0] p1;
    logic [PW-1:0] po1;
    logic          pv1;
    logic          e1;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;
    bit cmp_en = 1'b0;
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    bnn_stream_loader #(
        .FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(CC), .EVAL_CYCLES(EC)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .features(features), .clf_rst(clf_rst), .prediction(prediction),
        .pred_out(pred_out), .pred_valid(pred_valid), .pred_ready(pred_ready), .err_len(err_len)
    );

    bnn_stream_loader #(
        .FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(CC), .EVAL_CYCLES(1)
    ) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_last(l1),
        .in_ready(r1), .features(f1), .clf_rst(c1), .prediction(p1),
        .pred_out(po1), .pred_valid(pv1), .pred_ready(1'b1), .err_len(e1)
    );

    // Stand-in classifier for the fast instance: class is the feature sum modulo CLASS_CNT.
    function automatic logic [PW-1:0] pred_of(input logic [FW-1:0] v);
        int s = 0;
        for (int i = 0; i < FC; i++) s += int'(v[i*FB +: FB]);
        return PW'(s % CC);
    endfunction
    assign p1 = pred_of(f1);

    task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: shadow fill plus an evaluation slot timed by edge count.
    logic [FB-1:0] m_sh [FC];
    int            m_idx = 0;
    bit            m_full = 1'b0, m_full0, m_err = 1'b0, m_busy = 1'b0, m_pv = 1'b0, m_clf = 1'b1;
    logic [FW-1:0] m_feat = '0;
    logic [PW-1:0] m_pout = '0;
    int            m_cyc = 0, m_due = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_idx = 0; m_full = 1'b0; m_err = 1'b0; m_busy = 1'b0;
            m_pv = 1'b0; m_clf = 1'b1; m_feat = '0; m_pout = '0;
        end else begin
            m_full0 = m_full;
            m_cyc++;
            m_clf = 1'b0;
            if (!m_busy && m_full0) begin
                for (int i = 0; i < FC; i++) m_feat[i*FB +: FB] = m_sh[i];
                m_full = 1'b0; m_clf = 1'b1; m_busy = 1'b1; m_due = m_cyc + EC;
            end else if (m_busy && !m_pv && m_cyc == m_due) begin
                m_pv = 1'b1; m_pout = prediction;
            end else if (m_pv && pred_ready) begin
                m_pv = 1'b0; m_busy = 1'b0;
            end
            if (in_valid && !m_full0) begin
                m_sh[m_idx] = in_data;
                if (m_idx == FC - 1) begin
                    m_full = 1'b1; m_idx = 0;
                    if (!in_last) m_err = 1'b1;
                end else if (in_last) begin
                    m_err = 1'b1; m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", in_ready, !m_full);
            check("features", features, m_feat);
            check("clf_rst", clf_rst, m_clf);
            check("pred_valid", pred_valid, m_pv);
            check("pred_out", pred_out, m_pout);
            check("err_len", err_len, m_err);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            prediction = PW'($urandom_range(0, CC - 1));
            if (rand_ready) pred_ready = $urandom_range(0, 1) == 1;
        end
    end

    // Fast-instance monitor: feature vector at each restart, class and spacing of each result.
    logic [FW-1:0] xq [6];
    int            x_i = 0, p_i = 0;
    int            ptimes [6];
    bit            t8 = 1'b0;

    always @(negedge clk) begin
        if (t8) begin
            if (c1) begin
                if (x_i < 6) check("fast_features", f1, xq[x_i]);
                x_i++;
            end
            if (pv1) begin
                if (p_i < 6) begin
                    check("fast_pred", po1, pred_of(xq[p_i]));
                    ptimes[p_i] = edge_n;
                end
                p_i++;
            end
        end
    end

    task automatic beat(input logic [FB-1:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && n < 500) begin @(posedge clk); #1; n++; end
        check("beat_accept_timeout", (n < 500), 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send(input int n, input int last_at, input bit seq, output logic [FW-1:0] vec);
        logic [FB-1:0] d;
        vec = '0;
        for (int b = 0; b < n; b++) begin
            d = seq ? FB'(b % 16) : FB'($urandom);
            if (b < FC) vec[b*FB +: FB] = d;
            beat(d, b == last_at);
        end
    endtask

    task automatic wait_pv(output int e);
        int n = 0;
        while (!pred_valid && n < 300) begin @(posedge clk); #1; n++; end
        check("pred_valid_timeout", (n < 300), 1);
        e = edge_n;
    endtask

    task automatic check_reset_state();
        check("rst_features", features, '0);
        check("rst_pred_valid", pred_valid, 0);
        check("rst_clf_rst", clf_rst, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_err_len", err_len, 0);
        check("rst_pred_out", pred_out, 0);
    endtask

    logic [FW-1:0] vec, vec_b;
    int            e0, e;

    initial begin
        #2 rst = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_state();
        rst = 1'b1;
        @(posedge clk); #1;
        check("clf_rst_release", clf_rst, 0);

        // Sequential sample, latency and restart pulse.
        pred_ready = 1'b1;
        send(FC, FC - 1, 1'b1, vec);
        e0 = edge_n;
        check("clf_rst_before_xfer", clf_rst, 0);
        @(posedge clk); #1;
        check("clf_rst_pulse", clf_rst, 1);
        check("features_literal", features, 76'h210FEDCBA9876543210);
        @(posedge clk); #1;
        check("clf_rst_drop", clf_rst, 0);
        wait_pv(e);
        check("latency", FW'(e - e0), FW'(43));

        // Backpressure with a second sample filled during HOLD.
        @(posedge clk); #1;
        pred_ready = 1'b0;
        send(FC, FC - 1, 1'b0, vec);
        wait_pv(e);
        send(FC, FC - 1, 1'b0, vec_b);
        check("bp_in_ready_low", in_ready, 0);
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_hold_valid", pred_valid, 1);
            check("bp_features_a", features, vec);
        end
        pred_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released", pred_valid, 0);
        check("bp_no_xfer_yet", clf_rst, 0);
        @(posedge clk); #1;
        check("bp_xfer", clf_rst, 1);
        check("bp_features_b", features, vec_b);
        wait_pv(e);

        // Early in_last discards the partial sample.
        @(posedge clk); #1;
        check("err_before", err_len, 0);
        send(5, 4, 1'b0, vec);
        check("err_early_last", err_len, 1);
        send(FC, FC - 1, 1'b0, vec);
        wait_pv(e);
        check("features_after_err", features, vec);

        // Missing in_last: flagged, still evaluated.
        @(posedge clk); #1;
        rst = 1'b0;
        #1 check_reset_state();
        @(posedge clk); #1;
        rst = 1'b1;
        send(FC, -1, 1'b0, vec);
        check("err_no_last", err_len, 1);
        wait_pv(e);
        check("features_no_last", features, vec);

        // Reset in the middle of RUN.
        @(posedge clk); #1;
        send(FC, FC - 1, 1'b0, vec);
        e0 = edge_n;
        repeat (22) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_state();
        @(posedge clk); #1;
        rst = 1'b1;
        send(FC, FC - 1, 1'b0, vec);
        wait_pv(e);
        check("features_after_reset", features, vec);

        // Randomised traffic against the model.
        rand_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            for (int b = 0; b < FC; b++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                beat(FB'($urandom), (b == FC - 1) || ($urandom_range(0, 60) == 0));
            end
        end
        rand_ready = 1'b0;
        pred_ready = 1'b1;
        repeat (150) @(posedge clk);
        #1;

        // Fast instance: back-to-back samples with pred_ready tied high.
        t8 = 1'b1;
        for (int s = 0; s < 6; s++) begin
            for (int b = 0; b < FC; b++) begin
                int n = 0;
                v1 = 1'b1; d1 = FB'($urandom); l1 = (b == FC - 1);
                xq[s][b*FB +: FB] = d1;
                while (!r1 && n < 100) begin @(posedge clk); #1; n++; end
                @(posedge clk); #1;
            end
        end
        v1 = 1'b0; l1 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("fast_xfer_count", FW'(x_i), FW'(6));
        check("fast_pred_count", FW'(p_i), FW'(6));
        for (int k = 1; k < 6; k++) begin
            check("fast_interval_ok",
                  ((ptimes[k] - ptimes[k-1]) >= FC) && ((ptimes[k] - ptimes[k-1]) <= FC + 1), 1);
        end
        check("fast_err", e1, 0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
